// File: rtl/fir_dec_buffer_if.sv
// rtl/fir_dec_buffer_if.sv - sample stream, decimation control and FIFO status bundle
interface fir_dec_buffer_if #(
  parameter int NB    = 9,
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [NB-1:0] din;
  logic          vin;
  logic [2:0]    dec;
  logic          rdy;
  logic [NB-1:0] dout;
  logic          vout;
  logic [LW-1:0] level;
  logic          ovf;

  modport master (
    output din, vin, dec, rdy,
    input  dout, vout, level, ovf
  );

  modport slave (
    input  din, vin, dec, rdy,
    output dout, vout, level, ovf
  );
endinterface

// File: rtl/fir_dec_buffer.sv
// rtl/fir_dec_buffer.sv - keep every (dec+1)-th valid filter sample and buffer it in a FIFO
module fir_dec_buffer #(
  parameter int NB    = 9,
  parameter int DEPTH = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  fir_dec_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [2:0]    phase_q, phase_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [NB-1:0] mem_q [DEPTH];

  logic empty;
  logic full;
  logic keep;
  logic pop;
  logic push;

  always_comb begin
    empty = (level_q == '0);
    full  = (level_q == LW'(DEPTH));
    pop   = !empty && bus.rdy;
    keep  = bus.vin && (phase_q == 3'd0);
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    push  = keep && (!full || pop);
  end

  always_comb begin
    phase_d = phase_q;
    if (bus.vin) begin
      phase_d = (phase_q >= bus.dec) ? 3'd0 : phase_q + 3'd1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (keep && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      phase_q  <= 3'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; only the pointers and level define what is valid.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push) begin
      mem_q[wr_ptr_q] <= bus.din;
    end
  end

  assign bus.vout  = !empty;
  assign bus.dout  = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.level = level_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_fir_dec_buffer.sv
// tb/tb_fir_dec_buffer.sv - scoreboard bench for fir_dec_buffer
module tb_fir_dec_buffer;
  localparam int NB    = 9;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_dec_buffer_if #(.NB(NB), .DEPTH(DEPTH)) bus ();

  fir_dec_buffer #(.NB(NB), .DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [NB-1:0] exp_q[$];
  int  model_level = 0;
  int  model_phase = 0;
  bit  model_ovf   = 1'b0;
  bit  mon_en      = 1'b0;
  bit  lvl_watch   = 1'b0;
  int  pop_cnt     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: phase rule, bounded queue with drop-on-full, sticky overflow.
  always @(posedge clk) begin
    bit do_pop;
    bit do_keep;
    if (!rst_n) begin
      model_level = 0;
      model_phase = 0;
      model_ovf   = 1'b0;
      exp_q.delete();
    end else begin
      do_pop  = (model_level > 0) && bus.rdy;
      do_keep = bus.vin && (model_phase == 0);
      if (bus.vin) model_phase = (model_phase >= int'(bus.dec)) ? 0 : model_phase + 1;
      if (do_keep) begin
        if (model_level < DEPTH || do_pop) begin
          exp_q.push_back(bus.din);
          model_level++;
        end else begin
          model_ovf = 1'b1;
        end
      end
      if (do_pop) model_level--;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("vout", bus.vout, model_level != 0);
      chk("level", bus.level, model_level);
      chk("ovf", bus.ovf, model_ovf);
      if (!bus.vout) begin
        chk("dout_idle", bus.dout, 0);
      end else if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_underflow: got dout %0d with nothing expected", bus.dout);
      end else begin
        chk("dout_head", bus.dout, exp_q[0]);
        if (bus.rdy) begin
          void'(exp_q.pop_front());
          pop_cnt++;
        end
      end
      if (lvl_watch) chk("pass_level_le1", bus.level <= 1, 1);
    end
  end

  task automatic drive(input logic v, input logic [NB-1:0] d, input logic r);
    @(posedge clk);
    #1;
    bus.vin = v;
    bus.din = d;
    bus.rdy = r;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    bus.vin = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) drive(1'b0, '0, r);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    logic [NB-1:0] neg4;
    neg4 = 9'h1FC;
    bus.vin = 1'b1;
    bus.rdy = 1'b1;
    bus.din = 9'h0AA;
    bus.dec = 3'd0;

    // Reset held with traffic present
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_vout", bus.vout, 0);
      chk("rst_dout", bus.dout, 0);
      chk("rst_level", bus.level, 0);
      chk("rst_ovf", bus.ovf, 0);
      mon_en = 1'b1;
    end
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    bus.vin = 1'b0;

    // Pass-through
    lvl_watch = 1'b1;
    base = pop_cnt;
    drive(1'b1, 9'd1, 1'b1);
    drive(1'b1, 9'd2, 1'b1);
    drive(1'b1, 9'd3, 1'b1);
    drive(1'b1, neg4, 1'b1);
    drive(1'b1, 9'd5, 1'b1);
    idle(4, 1'b1);
    lvl_watch = 1'b0;
    chk("pass_count", pop_cnt - base, 5);

    // Decimation by 3 then by 8
    bus.dec = 3'd2;
    base = pop_cnt;
    for (int i = 0; i < 10; i++) drive(1'b1, NB'(i), 1'b1);
    idle(4, 1'b1);
    chk("dec2_count", pop_cnt - base, 4);
    pulse_reset();
    bus.dec = 3'd7;
    base = pop_cnt;
    for (int i = 0; i < 16; i++) drive(1'b1, NB'(i), 1'b1);
    idle(4, 1'b1);
    chk("dec7_count", pop_cnt - base, 2);

    // Overflow
    pulse_reset();
    bus.dec = 3'd0;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, NB'(i), 1'b0);
      @(negedge clk);
      if (i == 9) begin
        chk("ovf_level_full", bus.level, 8);
        chk("ovf_not_yet", bus.ovf, 0);
      end
      if (i == 10) chk("ovf_set", bus.ovf, 1);
    end
    base = pop_cnt;
    idle(12, 1'b1);
    @(negedge clk);
    chk("ovf_drain_count", pop_cnt - base, 8);
    chk("ovf_sticky", bus.ovf, 1);
    chk("ovf_empty", bus.vout, 0);

    // Full with simultaneous push and pop
    pulse_reset();
    for (int i = 1; i <= 8; i++) drive(1'b1, NB'(i), 1'b0);
    drive(1'b1, 9'd100, 1'b1);
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("full_pp_level", bus.level, 8);
    chk("full_pp_ovf", bus.ovf, 0);
    chk("full_pp_head", bus.dout, 2);
    idle(12, 1'b1);

    // Reset mid-run
    pulse_reset();
    bus.dec = 3'd3;
    for (int i = 0; i < 17; i++) drive(1'b1, NB'(i + 20), 1'b0);
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("mid_level5", bus.level, 5);
    pulse_reset();
    @(negedge clk);
    chk("mid_vout", bus.vout, 0);
    chk("mid_level", bus.level, 0);
    chk("mid_ovf", bus.ovf, 0);
    drive(1'b1, 9'd55, 1'b1);
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    chk("mid_first_kept_level", bus.level, 1);
    chk("mid_first_kept_dout", bus.dout, 55);
    idle(3, 1'b1);

    // Randomized traffic with varying backpressure, decimation and resets
    for (int blk = 0; blk < 30; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(10, 100);
      for (int c = 0; c < 100; c++) begin
        if ($urandom_range(0, 40) == 0) bus.dec = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 600) == 0) begin
          pulse_reset();
        end else begin
          drive($urandom_range(0, 3) != 0, NB'($urandom), $urandom_range(1, 100) <= rdy_pct);
        end
      end
    end
    idle(20, 1'b1);
    @(negedge clk);
    chk("final_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_dec_buffer.md
# fir_dec_buffer

Downstream stage of the FIR filter. It takes the filter's 9-bit output stream (DOUT/VOUT), keeps every (DEC+1)-th valid sample, and stores the kept samples in a small FIFO. The FIFO drains to a consumer that can apply backpressure. It decouples the filter, which has no stall input, from slower sinks, and it reports any sample lost to overflow through a sticky flag.

## Interface
- NB, 9: sample width; samples are two's complement and pass through unchanged.
- DEPTH, 8: FIFO entries; must be a power of 2, at least 2.
- CLK  in  1  clock; all logic is rising-edge.
- RST_n  in  1  reset; synchronous, active-low.
- DIN  in  NB  filter output sample.
- VIN  in  1  DIN valid for this cycle (connects to the filter's VOUT).
- DEC  in  3  decimation factor minus 1 (0 = keep all, 7 = keep 1 of 8).
- RDY  in  1  consumer ready to take the head sample this cycle.
- DOUT  out  NB  head sample; 0 when VOUT=0.
- VOUT  out  1  FIFO non-empty.
- LEVEL  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- OVF  out  1  sticky overflow flag; cleared only by reset.

## Operation
- **Phase counter** (3 bits): updates only when VIN=1.
  - If phase >= DEC, phase <= 0; otherwise phase <= phase+1.
  - A sample is kept iff VIN=1 and phase==0 in that cycle.
  - When DEC changes while phase > new DEC, phase wraps to 0 on the next VIN.
- **Pop**: occurs when VOUT=1 and RDY=1. The read pointer advances and the head leaves.
- **Push**: the kept sample is written at the write pointer if LEVEL<DEPTH, or if LEVEL==DEPTH and a pop occurs in the same cycle.
- **Overflow**: a kept sample arriving with LEVEL==DEPTH and no pop is dropped, and OVF <= 1. FIFO contents are untouched.
- **Push and pop in the same cycle**:
  - LEVEL is unchanged.
  - Order is preserved.
  - This is legal at LEVEL==DEPTH.
  - At LEVEL==0 a pop cannot occur, so only the push takes effect.
- **Level and flags**:
  - LEVEL increments on push only, decrements on pop only.
  - VOUT = (LEVEL != 0).
  - DOUT = VOUT ? mem[rd_ptr] : 0.
- **Pointers**: log2(DEPTH) bits, wrap naturally from DEPTH-1 to 0.
- **Empty FIFO**: there is no bypass path; a sample written into an empty FIFO becomes visible on the following cycle.
- **Reset** (RST_n=0 at a rising edge), including mid-operation:
  - Pointers, LEVEL, phase and OVF go to 0.
  - VOUT=0, DOUT=0.
  - Memory contents need not be cleared.
  - VIN and RDY are ignored during reset.

## Timing
- Latency: a kept sample accepted at edge n gives VOUT=1 with DOUT=that sample after edge n, given the FIFO was empty.
- Throughput: one push and one pop per cycle. With DEC=0 and RDY held high, LEVEL never exceeds 1.
- The consumer samples DOUT when VOUT&RDY is high at a rising edge; the next head appears after that edge.
- The block is ready one cycle after RST_n returns high; the first VIN in that cycle is processed with phase=0.
- All outputs are registered state, or state gated by registered VOUT; there is no combinational path from RDY or VIN to any output.

## Test plan
- **Reset with input active**: hold RST_n=0 for 3 cycles with VIN=1 and RDY=1 → VOUT=0, DOUT=0, LEVEL=0, OVF=0 throughout.
- **Pass-through**: DEC=0, RDY=1, VIN=1 with DIN=1,2,3,-4,5 on consecutive cycles → DOUT=1,2,3,-4,5 on the following cycles, each one cycle late; LEVEL<=1; OVF=0.
- **Decimation**: DEC=2, RDY=1, DIN=0..9 continuous → outputs 0,3,6,9 only. Repeat with DEC=7 and DIN=0..15 → outputs 0,8.
- **Overflow**: DEC=0, RDY=0, DIN=1..10 → LEVEL=8 after the 8th sample; OVF=1 after the 9th. Then RDY=1, VIN=0 → outputs 1..8 in order, then VOUT=0; OVF stays 1.
- **Full with simultaneous push/pop**: fill 8 entries with 1..8, then one cycle with RDY=1, VIN=1, DIN=100 → LEVEL stays 8, OVF=0. Drain → 2..8,100.
- **Reset mid-run**: LEVEL=5, phase=1 with DEC=3, pulse RST_n=0 for one edge → next cycle VOUT=0, LEVEL=0, OVF=0. The next VIN sample is kept (phase=0).
